// File: rtl/mem_read_if.sv
// Bundled control and BRAM-side signals of the mem_read sequencer.
// slave is the sequencer side; master is the job source plus BRAM data return.
interface mem_read_if #(
    parameter int D_W          = 32,
    parameter int N            = 4,
    parameter int MATRIXSIZE_W = 16,
    parameter int ADDR_W       = 12
);
    logic                          start;
    logic [MATRIXSIZE_W-1:0]       rd_len;
    logic [MATRIXSIZE_W-1:0]       num_pass;
    logic [N*ADDR_W-1:0]           rd_addr_bram;
    logic [N-1:0]                  rd_en_bram;
    logic signed [N*D_W-1:0]       rd_data_bram;
    logic signed [N*D_W-1:0]       out_data;
    logic [N-1:0]                  out_valid;
    logic                          busy;
    logic                          done;

    modport slave (
        input  start, rd_len, num_pass, rd_data_bram,
        output rd_addr_bram, rd_en_bram, out_data, out_valid, busy, done
    );
    modport master (
        output start, rd_len, num_pass, rd_data_bram,
        input  rd_addr_bram, rd_en_bram, out_data, out_valid, busy, done
    );
endinterface

// File: rtl/mem_read.sv
// Multi-bank BRAM read sequencer: sweeps 0..rd_len-1 for num_pass passes, one lane per bank.
// Define SKEW_EN to delay bank x by x cycles (array-diagonal feed); undefined, all banks align.
module mem_read_lane #(
    parameter int ADDR_W = 12,
    parameter int SKEW   = 0,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              out_valid
);
    logic [RD_LAT:1] vld_pipe;

    if (SKEW == 0) begin : g_noskew
        assign rd_en   = en;
        assign rd_addr = addr;
    end else begin : g_skew
        logic [SKEW-1:0]             en_sr;
        logic [SKEW-1:0][ADDR_W-1:0] addr_sr;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                en_sr   <= '0;
                addr_sr <= '0;
            end else begin
                en_sr[0]   <= en;
                addr_sr[0] <= addr;
                for (int i = 1; i < SKEW; i++) begin
                    en_sr[i]   <= en_sr[i-1];
                    addr_sr[i] <= addr_sr[i-1];
                end
            end
        end
        assign rd_en   = en_sr[SKEW-1];
        assign rd_addr = addr_sr[SKEW-1];
    end

    // Valid tracks the BRAM read latency so it lines up with returning data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_en;
            for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end
    assign out_valid = vld_pipe[RD_LAT];
endmodule

module mem_read #(
    parameter int D_W          = 32,
    parameter int N            = 4,
    parameter int MATRIXSIZE_W = 16,
    parameter int ADDR_W       = 12,
    parameter int RD_LAT       = 1
) (
    input logic     clk,
    input logic     rst_n,
    mem_read_if.slave bus
);
`ifdef SKEW_EN
    localparam int S = 1;
`else
    localparam int S = 0;
`endif
    localparam int CW        = (ADDR_W > MATRIXSIZE_W) ? ADDR_W : MATRIXSIZE_W;
    localparam int DRAIN_LEN = S*(N-1) + RD_LAT;
    localparam int DCW       = $clog2(DRAIN_LEN + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic [MATRIXSIZE_W-1:0] len_q, pass_q, pass_cnt, len_m1;
    logic [ADDR_W-1:0]       addr_cnt;
    logic [DCW-1:0]          drain_cnt;
    logic                    accept, empty, wrap, last_rd, drain_end, en0;

    logic [N-1:0]             rd_en_v, vld_v;
    logic [N-1:0][ADDR_W-1:0] rd_addr_v;

    assign accept    = bus.start && (state == IDLE || state == DONE);
    assign empty     = (bus.rd_len == '0) || (bus.num_pass == '0);
    assign len_m1    = len_q - MATRIXSIZE_W'(1);
    assign wrap      = (CW'(addr_cnt) == CW'(len_m1));
    assign last_rd   = wrap && (pass_cnt == pass_q - MATRIXSIZE_W'(1));
    assign drain_end = (drain_cnt == DCW'(DRAIN_LEN - 1));
    assign en0       = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                if (accept) state_nx = empty ? DONE : RUN;
            end
            RUN:     if (last_rd)   state_nx = DRAIN;
            DRAIN:   if (drain_end) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Pass counter instead of an L-wide product: the address wrap steps the pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q     <= '0;
            pass_q    <= '0;
            pass_cnt  <= '0;
            addr_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            if (accept) begin
                len_q    <= bus.rd_len;
                pass_q   <= bus.num_pass;
                pass_cnt <= '0;
                addr_cnt <= '0;
            end else if (state == RUN) begin
                if (wrap) begin
                    addr_cnt <= '0;
                    pass_cnt <= pass_cnt + MATRIXSIZE_W'(1);
                end else begin
                    addr_cnt <= addr_cnt + ADDR_W'(1);
                end
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + DCW'(1) : '0;
        end
    end

    for (genvar x = 0; x < N; x++) begin : g_lane
        mem_read_lane #(.ADDR_W(ADDR_W), .SKEW(S*x), .RD_LAT(RD_LAT)) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en0),
            .addr      (addr_cnt),
            .rd_en     (rd_en_v[x]),
            .rd_addr   (rd_addr_v[x]),
            .out_valid (vld_v[x])
        );
    end

    assign bus.rd_en_bram   = rd_en_v;
    assign bus.rd_addr_bram = rd_addr_v;
    assign bus.out_valid    = vld_v;
    assign bus.out_data     = bus.rd_data_bram;
    assign bus.busy         = (state == RUN) || (state == DRAIN);
    assign bus.done         = (state == DONE);
endmodule

// File: tb/tb_mem_read.sv
// Directed bench for mem_read: cycle-exact enable/address/valid/busy/done timing.
// Skew expectations follow SKEW_EN as seen at compile time.
module tb_mem_read;
`ifdef SKEW_EN
    localparam int S = 1;
`else
    localparam int S = 0;
`endif
    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_read_if #(.D_W(DW), .N(N), .MATRIXSIZE_W(16), .ADDR_W(AW)) bus ();
    mem_read_if #(.D_W(DW), .N(N), .MATRIXSIZE_W(16), .ADDR_W(AW)) bus3 ();

    mem_read #(.D_W(DW), .N(N), .MATRIXSIZE_W(16), .ADDR_W(AW), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));
    mem_read #(.D_W(DW), .N(N), .MATRIXSIZE_W(16), .ADDR_W(AW), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    // Job started in cycle 0 with L reads per bank: bank x enabled in cycles 1+S*x..L+S*x.
    function automatic bit exp_en(int c, int x, int L);
        return (L > 0) && (c >= 1 + S*x) && (c <= L + S*x);
    endfunction

    function automatic int exp_addr(int c, int x, int len);
        return (c - 1 - S*x) % len;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.rd_en_bram !== '0 || bus.rd_addr_bram !== '0 || bus.out_valid !== '0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_lat1 en=%h addr=%h vld=%h busy=%b done=%b exp all 0",
                     bus.rd_en_bram, bus.rd_addr_bram, bus.out_valid, bus.busy, bus.done);
        end
        checks++;
        if (bus3.rd_en_bram !== '0 || bus3.rd_addr_bram !== '0 || bus3.out_valid !== '0 ||
            bus3.busy !== 1'b0 || bus3.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_lat3 en=%h vld=%h busy=%b done=%b exp all 0",
                     bus3.rd_en_bram, bus3.out_valid, bus3.busy, bus3.done);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs one job (optionally a second one launched in the DONE cycle) and checks every cycle.
    task automatic test_job(input string name, input int len, input int pass,
                            input int repulse, input bit chain);
        int L, d, t2, span, c2, ea, e_d, e_b;
        bit e1, e2, v;
        L    = len * pass;
        d    = (L > 0) ? L + S*(N-1) + 1 + 1 : 1;
        t2   = chain ? d : -1000;
        span = chain ? t2 + d + 2 : d + 2;
        bus.rd_len   = 16'(len);
        bus.num_pass = 16'(pass);
        bus.start    = 1'b1;
        for (int c = 1; c <= span; c++) begin
            @(negedge clk);
            c2 = c - t2;
            for (int x = 0; x < N; x++) begin
                e1 = exp_en(c, x, L);
                e2 = chain && exp_en(c2, x, L);
                checks++;
                if (bus.rd_en_bram[x] !== (e1 | e2)) begin
                    failures++;
                    $display("FAIL %s rd_en c=%0d bank=%0d got=%b exp=%b",
                             name, c, x, bus.rd_en_bram[x], e1 | e2);
                end
                if (e1 | e2) begin
                    ea = e1 ? exp_addr(c, x, len) : exp_addr(c2, x, len);
                    checks++;
                    if (bus.rd_addr_bram[x*AW +: AW] !== AW'(ea)) begin
                        failures++;
                        $display("FAIL %s rd_addr c=%0d bank=%0d got=%0d exp=%0d",
                                 name, c, x, bus.rd_addr_bram[x*AW +: AW], ea);
                    end
                end
                v = exp_en(c - 1, x, L) || (chain && exp_en(c2 - 1, x, L));
                checks++;
                if (bus.out_valid[x] !== v) begin
                    failures++;
                    $display("FAIL %s out_valid c=%0d bank=%0d got=%b exp=%b",
                             name, c, x, bus.out_valid[x], v);
                end
                if (v) begin
                    checks++;
                    if (bus.out_data[x*DW +: DW] !== bus.rd_data_bram[x*DW +: DW]) begin
                        failures++;
                        $display("FAIL %s out_data c=%0d bank=%0d got=%h exp=%h", name, c, x,
                                 bus.out_data[x*DW +: DW], bus.rd_data_bram[x*DW +: DW]);
                    end
                end
            end
            e_b = int'((L > 0) && ((c >= 1 && c <= d - 1) || (chain && c2 >= 1 && c2 <= d - 1)));
            e_d = int'((c == d) || (chain && c2 == d));
            checks++;
            if (bus.busy !== e_b[0]) begin
                failures++;
                $display("FAIL %s busy c=%0d got=%b exp=%b", name, c, bus.busy, e_b[0]);
            end
            checks++;
            if (bus.done !== e_d[0]) begin
                failures++;
                $display("FAIL %s done c=%0d got=%b exp=%b", name, c, bus.done, e_d[0]);
            end
            // Inputs move after sampling; latched parameters must not follow them.
            bus.start        = 1'b0;
            bus.rd_len       = 16'(len + 1);
            bus.num_pass     = 16'(pass + 2);
            bus.rd_data_bram = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (c == repulse) bus.start = 1'b1;
            if (chain && c == t2) begin
                bus.start    = 1'b1;
                bus.rd_len   = 16'(len);
                bus.num_pass = 16'(pass);
            end
        end
    endtask

    task automatic test_basic();
        test_job("basic_3x2", 3, 2, 0, 1'b0);
        test_job("single_5x1", 5, 1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        test_job("repulse_chain", 3, 2, 4, 1'b1);
    endtask

    task automatic test_empty();
        test_job("empty_len0", 0, 5, 0, 1'b0);
        test_job("empty_pass0", 4, 0, 0, 1'b0);
    endtask

    task automatic test_abort();
        bus.rd_len   = 16'd4;
        bus.num_pass = 16'd3;
        bus.start    = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            checks++;
            if (bus.rd_en_bram[0] !== 1'b1 || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL abort_run c=%0d en0=%b busy=%b exp 1 1",
                         c, bus.rd_en_bram[0], bus.busy);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rd_en_bram !== '0 || bus.rd_addr_bram !== '0 || bus.out_valid !== '0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL abort_async en=%h addr=%h vld=%h busy=%b done=%b exp all 0",
                     bus.rd_en_bram, bus.rd_addr_bram, bus.out_valid, bus.busy, bus.done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.rd_en_bram !== '0) begin
                failures++;
                $display("FAIL abort_nodone c=%0d done=%b en=%h exp 0 0",
                         c, bus.done, bus.rd_en_bram);
            end
        end
        test_job("restart_3x2", 3, 2, 0, 1'b0);
    endtask

    task automatic test_rd_lat3();
        int en_c, v_c, d_c;
        en_c = 1 + S*3;
        v_c  = en_c + 3;
        d_c  = v_c + 1;
        bus3.rd_len   = 16'd1;
        bus3.num_pass = 16'd1;
        bus3.start    = 1'b1;
        for (int c = 1; c <= d_c + 2; c++) begin
            @(negedge clk);
            bus3.start = 1'b0;
            checks++;
            if (bus3.rd_en_bram[3] !== (c == en_c)) begin
                failures++;
                $display("FAIL lat3 rd_en3 c=%0d got=%b exp=%b", c, bus3.rd_en_bram[3], c == en_c);
            end
            checks++;
            if (bus3.out_valid[3] !== (c == v_c)) begin
                failures++;
                $display("FAIL lat3 out_valid3 c=%0d got=%b exp=%b", c, bus3.out_valid[3], c == v_c);
            end
            checks++;
            if (bus3.done !== (c == d_c)) begin
                failures++;
                $display("FAIL lat3 done c=%0d got=%b exp=%b", c, bus3.done, c == d_c);
            end
            checks++;
            if (bus3.busy !== (c >= 1 && c < d_c)) begin
                failures++;
                $display("FAIL lat3 busy c=%0d got=%b exp=%b", c, bus3.busy, c >= 1 && c < d_c);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;  bus.rd_len = '0;  bus.num_pass = '0;  bus.rd_data_bram = '0;
        bus3.start = 1'b0; bus3.rd_len = '0; bus3.num_pass = '0; bus3.rd_data_bram = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_empty();
        test_abort();
        test_rd_lat3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
